// File: rtl/code_sequencer.sv
// Game-side sequencer for the peg scorer: holds the secret code, accepts guesses,
// walks the scorer across every peg, then reports red/white counts and win/lose.
module code_sequencer #(
    parameter int PEG_W       = 3,
    parameter int NUM_PEGS    = 4,
    parameter int MAX_GUESSES = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_code,
    input  logic [PEG_W*NUM_PEGS-1:0] code_in,
    input  logic                      guess_valid,
    input  logic [PEG_W*NUM_PEGS-1:0] guess_in,
    output logic                      guess_ready,
    output logic                      compare_resetn,
    output logic                      compareEn,
    output logic [1:0]                compare_i,
    output logic [PEG_W-1:0]          curr_code,
    output logic [PEG_W*NUM_PEGS-1:0] compare_guess,
    input  logic [2:0]                red_in,
    input  logic [2:0]                white_in,
    output logic                      result_valid,
    output logic [2:0]                red_out,
    output logic [2:0]                white_out,
    output logic [3:0]                guess_count,
    output logic                      win,
    output logic                      lose
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_CLEAR,
        S_COMPARE,
        S_SETTLE,
        S_WIN,
        S_LOSE
    } state_t;

    state_t                      r_state;
    logic [PEG_W*NUM_PEGS-1:0]   r_code;
    logic [PEG_W*NUM_PEGS-1:0]   r_guess;
    logic [1:0]                  r_idx;
    logic                        r_ready;
    logic                        r_clr_n;
    logic                        r_en;
    logic                        r_rvalid;
    logic [2:0]                  r_red;
    logic [2:0]                  r_white;
    logic [3:0]                  r_count;
    logic                        r_win;
    logic                        r_lose;

    logic [3:0]                  w_next_count;
    logic                        w_last_idx;

    assign w_next_count = r_count + 4'd1;
    assign w_last_idx   = (r_idx == 2'(NUM_PEGS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_code   <= '0;
            r_guess  <= '0;
            r_idx    <= '0;
            r_ready  <= 1'b0;
            r_clr_n  <= 1'b0;
            r_en     <= 1'b0;
            r_rvalid <= 1'b0;
            r_red    <= '0;
            r_white  <= '0;
            r_count  <= '0;
            r_win    <= 1'b0;
            r_lose   <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            // A new code restarts the game from any state, dropping any guess in flight
            if (load_code) begin
                r_state <= S_READY;
                r_code  <= code_in;
                r_count <= '0;
                r_win   <= 1'b0;
                r_lose  <= 1'b0;
                r_red   <= '0;
                r_white <= '0;
                r_ready <= 1'b1;
                r_clr_n <= 1'b1;
                r_en    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end
                    S_READY: begin
                        if (guess_valid) begin
                            r_state <= S_CLEAR;
                            r_guess <= guess_in;
                            r_ready <= 1'b0;
                            r_clr_n <= 1'b0;
                            r_idx   <= '0;
                        end
                    end
                    S_CLEAR: begin
                        r_state <= S_COMPARE;
                        r_clr_n <= 1'b1;
                        r_en    <= 1'b1;
                    end
                    S_COMPARE: begin
                        if (w_last_idx) begin
                            r_state <= S_SETTLE;
                            r_en    <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                    S_SETTLE: begin
                        // Scorer totals are final here; win outranks lose on the last guess
                        r_red    <= red_in;
                        r_white  <= white_in;
                        r_count  <= w_next_count;
                        r_rvalid <= 1'b1;
                        if (red_in == 3'(NUM_PEGS)) begin
                            r_state <= S_WIN;
                            r_win   <= 1'b1;
                        end else if (w_next_count == 4'(MAX_GUESSES)) begin
                            r_state <= S_LOSE;
                            r_lose  <= 1'b1;
                        end else begin
                            r_state <= S_READY;
                            r_ready <= 1'b1;
                        end
                    end
                    S_WIN, S_LOSE: begin
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b0;
                        r_clr_n <= 1'b0;
                        r_en    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign guess_ready    = r_ready;
    assign compare_resetn = r_clr_n;
    assign compareEn      = r_en;
    assign compare_i      = r_idx;
    assign curr_code      = r_code[int'(r_idx)*PEG_W +: PEG_W];
    assign compare_guess  = r_guess;
    assign result_valid   = r_rvalid;
    assign red_out        = r_red;
    assign white_out      = r_white;
    assign guess_count    = r_count;
    assign win            = r_win;
    assign lose           = r_lose;

endmodule

// File: tb/tb_code_sequencer.sv
// Directed bench for code_sequencer: the scorer is stood in for by driving red_in/white_in
// with hand-chosen totals, and every output is checked on a cycle-exact schedule.
module tb_code_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_code;
    logic [11:0] code_in;
    logic        guess_valid;
    logic [11:0] guess_in;
    logic        guess_ready;
    logic        compare_resetn;
    logic        compareEn;
    logic [1:0]  compare_i;
    logic [2:0]  curr_code;
    logic [11:0] compare_guess;
    logic [2:0]  red_in;
    logic [2:0]  white_in;
    logic        result_valid;
    logic [2:0]  red_out;
    logic [2:0]  white_out;
    logic [3:0]  guess_count;
    logic        win;
    logic        lose;

    logic [11:0] tb_code;
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [11:0] CODE_1234 = 12'b100_011_010_001;
    localparam logic [11:0] GUESS_2143 = 12'b011_100_001_010;
    localparam logic [11:0] CODE_5670 = 12'b000_111_110_101;
    localparam logic [11:0] GUESS_MISS = 12'b110_110_110_110;

    code_sequencer #(.PEG_W(3), .NUM_PEGS(4), .MAX_GUESSES(10)) dut (
        .clock          (clock),
        .reset          (reset),
        .load_code      (load_code),
        .code_in        (code_in),
        .guess_valid    (guess_valid),
        .guess_in       (guess_in),
        .guess_ready    (guess_ready),
        .compare_resetn (compare_resetn),
        .compareEn      (compareEn),
        .compare_i      (compare_i),
        .curr_code      (curr_code),
        .compare_guess  (compare_guess),
        .red_in         (red_in),
        .white_in       (white_in),
        .result_valid   (result_valid),
        .red_out        (red_out),
        .white_out      (white_out),
        .guess_count    (guess_count),
        .win            (win),
        .lose           (lose)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Full guess from acceptance edge through the result cycle; returns in the cycle after capture
    task automatic do_guess(input logic [11:0] g, input logic [2:0] r, input logic [2:0] w);
        guess_in    = g;
        guess_valid = 1'b1;
        red_in      = r;
        white_in    = w;
        tick();
        guess_valid = 1'b0;
        chk("clear_resetn", compare_resetn, 0);
        chk("clear_en", compareEn, 0);
        chk("clear_ready", guess_ready, 0);
        chk("latched_guess", compare_guess, g);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cmp_en", compareEn, 1);
            chk("cmp_idx", compare_i, k);
            chk("cmp_peg", curr_code, tb_code[k*3 +: 3]);
        end
        tick();
        chk("settle_en", compareEn, 0);
        chk("settle_idx", compare_i, 3);
        chk("settle_rv", result_valid, 0);
        tick();
        chk("result_valid", result_valid, 1);
        chk("red_out", red_out, r);
        chk("white_out", white_out, w);
    endtask

    task automatic do_load(input logic [11:0] c);
        code_in   = c;
        tb_code   = c;
        load_code = 1'b1;
        tick();
        load_code = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        load_code   = 1'b0;
        code_in     = '0;
        guess_valid = 1'b0;
        guess_in    = '0;
        red_in      = '0;
        white_in    = '0;
        tb_code     = '0;

        repeat (2) tick();
        chk("rst_ready", guess_ready, 0);
        chk("rst_resetn", compare_resetn, 0);
        chk("rst_en", compareEn, 0);
        chk("rst_idx", compare_i, 0);
        chk("rst_guess", compare_guess, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_red", red_out, 0);
        chk("rst_white", white_out, 0);
        chk("rst_count", guess_count, 0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);
        reset = 1'b0;
        tick();
        chk("idle_ready", guess_ready, 0);

        // Code {1,2,3,4}, exact-match guess wins on the first try
        do_load(CODE_1234);
        chk("load_ready", guess_ready, 1);
        chk("load_resetn", compare_resetn, 1);
        chk("load_count", guess_count, 0);
        do_guess(CODE_1234, 3'd4, 3'd0);
        chk("win1_win", win, 1);
        chk("win1_lose", lose, 0);
        chk("win1_ready", guess_ready, 0);
        chk("win1_count", guess_count, 1);
        tick();
        chk("win1_rv_pulse", result_valid, 0);
        chk("win1_level", win, 1);
        guess_valid = 1'b1;
        repeat (3) tick();
        guess_valid = 1'b0;
        chk("win_ignore_en", compareEn, 0);
        chk("win_ignore_count", guess_count, 1);

        // Permuted guess {2,1,4,3}: all white, back to READY
        do_load(CODE_1234);
        chk("reload_win", win, 0);
        chk("reload_red", red_out, 0);
        chk("reload_count", guess_count, 0);
        do_guess(GUESS_2143, 3'd0, 3'd4);
        chk("perm_win", win, 0);
        chk("perm_ready", guess_ready, 1);
        chk("perm_count", guess_count, 1);

        // Nine more misses reach the guess limit; first one uses out-of-range totals
        for (int i = 0; i < 9; i++) begin
            do_guess(GUESS_MISS, (i == 0) ? 3'd5 : 3'd1, (i == 0) ? 3'd7 : 3'd2);
            chk("miss_count", guess_count, i + 2);
            chk("miss_win", win, 0);
            if (i < 8) begin
                chk("miss_ready", guess_ready, 1);
                chk("miss_lose", lose, 0);
            end
        end
        chk("lose_lose", lose, 1);
        chk("lose_ready", guess_ready, 0);
        guess_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("lose_ignore_en", compareEn, 0);
            chk("lose_ignore_rv", result_valid, 0);
        end
        guess_valid = 1'b0;
        chk("lose_hold_count", guess_count, 10);
        chk("lose_hold", lose, 1);

        // Win on the final allowed guess beats lose
        do_load(CODE_1234);
        chk("reload2_lose", lose, 0);
        chk("reload2_count", guess_count, 0);
        for (int i = 0; i < 9; i++) begin
            do_guess(GUESS_MISS, 3'd1, 3'd1);
        end
        chk("pre10_count", guess_count, 9);
        do_guess(CODE_1234, 3'd4, 3'd0);
        chk("win10_win", win, 1);
        chk("win10_lose", lose, 0);
        chk("win10_count", guess_count, 10);
        chk("win10_ready", guess_ready, 0);

        // Abort a guess mid-compare with a new code
        do_load(CODE_1234);
        do_guess(GUESS_2143, 3'd0, 3'd1);
        chk("pre_abort_count", guess_count, 1);
        guess_in    = CODE_1234;
        guess_valid = 1'b1;
        red_in      = 3'd4;
        tick();
        guess_valid = 1'b0;
        repeat (3) tick();
        chk("abort_mid_en", compareEn, 1);
        chk("abort_mid_idx", compare_i, 2);
        code_in   = CODE_1234;
        load_code = 1'b1;
        tick();
        load_code = 1'b0;
        chk("abort_ready", guess_ready, 1);
        chk("abort_en", compareEn, 0);
        chk("abort_resetn", compare_resetn, 1);
        chk("abort_count", guess_count, 0);
        chk("abort_white", white_out, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_rv", result_valid, 0);
        end
        chk("abort_count_hold", guess_count, 0);
        chk("abort_win", win, 0);

        // Load and guess in the same cycle: load wins, guess dropped
        code_in     = CODE_5670;
        tb_code     = CODE_5670;
        load_code   = 1'b1;
        guess_in    = GUESS_2143;
        guess_valid = 1'b1;
        tick();
        load_code   = 1'b0;
        guess_valid = 1'b0;
        chk("lg_ready", guess_ready, 1);
        chk("lg_resetn", compare_resetn, 1);
        tick();
        chk("lg_en", compareEn, 0);
        chk("lg_ready2", guess_ready, 1);
        do_guess(GUESS_2143, 3'd2, 3'd1);
        chk("newcode_count", guess_count, 1);
        chk("newcode_ready", guess_ready, 1);

        // Async reset between edges while in SETTLE
        guess_in    = CODE_5670;
        guess_valid = 1'b1;
        red_in      = 3'd4;
        white_in    = 3'd0;
        tick();
        guess_valid = 1'b0;
        repeat (5) tick();
        chk("pre_rst_en", compareEn, 0);
        chk("pre_rst_idx", compare_i, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ready", guess_ready, 0);
        chk("arst_resetn", compare_resetn, 0);
        chk("arst_idx", compare_i, 0);
        chk("arst_guess", compare_guess, 0);
        chk("arst_red", red_out, 0);
        chk("arst_white", white_out, 0);
        chk("arst_count", guess_count, 0);
        chk("arst_win", win, 0);
        chk("arst_curr", curr_code, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("arst_rv", result_valid, 0);
        guess_valid = 1'b1;
        tick();
        guess_valid = 1'b0;
        chk("arst_idle_ready", guess_ready, 0);
        chk("arst_idle_en", compareEn, 0);
        chk("arst_idle_resetn", compare_resetn, 0);
        do_load(CODE_1234);
        chk("arst_load_ready", guess_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
